// File: rtl/ram_uart_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : ram_uart_dumper
//  Description : Reads a window of words from the RAM adapter port and sends
//                one byte per word on an 8N1 UART line, LSB first. Optional
//                hex-digit encoding with a newline after every row.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_uart_dumper #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int BASE_ADDR    = 0,
  parameter int NUM_WORDS    = 100,
  parameter int READ_LATENCY = 1,
  parameter int ASCII_MODE   = 1,
  parameter int ROW_LEN      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [10:0] adapter_addr,
  input  logic [31:0] adapter_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  // One counter serves both bit timing and the fetch wait, so size it for
  // whichever needs the larger range.
  localparam int CNT_MAX = (CLKS_PER_BIT > READ_LATENCY + 1) ? CLKS_PER_BIT
                                                             : READ_LATENCY + 1;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int ROW_W   = $clog2(ROW_LEN + 1);

  localparam logic [CNT_W-1:0] C_BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_FETCH_LAST = CNT_W'(READ_LATENCY);
  localparam logic [10:0]      C_BASE       = 11'(BASE_ADDR);
  localparam logic [11:0]      C_NUM        = 12'(NUM_WORDS);
  localparam logic [ROW_W-1:0] C_ROW        = ROW_W'(ROW_LEN);
  localparam logic [7:0]       C_NEWLINE    = 8'h0A;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_START    = 4'd2;
  localparam logic [3:0] S_DATA     = 4'd3;
  localparam logic [3:0] S_STOP     = 4'd4;
  localparam logic [3:0] S_NL_START = 4'd5;
  localparam logic [3:0] S_NL_DATA  = 4'd6;
  localparam logic [3:0] S_NL_STOP  = 4'd7;
  localparam logic [3:0] S_FINISH   = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [10:0]      addr_q, addr_d;
  logic [11:0]      word_cnt_q, word_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_in_frame;
  logic             w_bit_end;
  logic             w_fetch_end;
  logic             w_last_word;
  logic             w_row_full;
  logic [ROW_W-1:0] w_row_inc;
  logic [3:0]       w_nib;
  logic [7:0]       w_hex;
  logic [7:0]       w_byte;
  logic             w_unused;

  // Upper data bits are never transmitted.
  assign w_unused = ^adapter_data[31:8];

  assign w_in_frame  = (state_q >= S_START) && (state_q <= S_NL_STOP);
  assign w_bit_end   = w_in_frame && (cnt_q == C_BIT_LAST);
  assign w_fetch_end = (state_q == S_FETCH) && (cnt_q == C_FETCH_LAST);
  assign w_last_word = ((word_cnt_q + 12'd1) == C_NUM);
  assign w_row_inc   = row_cnt_q + ROW_W'(1);
  assign w_row_full  = (w_row_inc == C_ROW);

  // Hex digit for the low nibble: '0'..'9' then 'A'..'F'.
  assign w_nib  = adapter_data[3:0];
  assign w_hex  = (w_nib < 4'd10) ? (8'h30 + {4'd0, w_nib}) : (8'h37 + {4'd0, w_nib});
  assign w_byte = (ASCII_MODE != 0) ? w_hex : adapter_data[7:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH:    if (w_fetch_end) state_d = S_START;
      S_START:    if (w_bit_end) state_d = S_DATA;
      S_DATA:     if (w_bit_end && (bit_cnt_q == 3'd7)) state_d = S_STOP;
      S_STOP: begin
        if (w_bit_end) begin
          if ((ASCII_MODE != 0) && w_row_full) state_d = S_NL_START;
          else if (w_last_word)                state_d = S_FINISH;
          else                                 state_d = S_FETCH;
        end
      end
      S_NL_START: if (w_bit_end) state_d = S_NL_DATA;
      S_NL_DATA:  if (w_bit_end && (bit_cnt_q == 3'd7)) state_d = S_NL_STOP;
      S_NL_STOP: begin
        // word_cnt was already advanced at the end of the preceding data frame.
        if (w_bit_end) state_d = (word_cnt_q == C_NUM) ? S_FINISH : S_FETCH;
      end
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-values; tx follows the current state, so the
  // line lags the state machine by one clock.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;

    // Baud/fetch counter restarts on every state entry and every bit boundary.
    if ((state_d != state_q) || w_bit_end || (state_q == S_IDLE) ||
        (state_q == S_FINISH)) begin
      cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = C_BASE;
          word_cnt_d = '0;
          row_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      S_FETCH: begin
        if (w_fetch_end) shift_d = w_byte;
      end
      S_DATA, S_NL_DATA: begin
        if (w_bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          word_cnt_d = word_cnt_q + 12'd1;
          row_cnt_d  = w_row_full ? '0 : w_row_inc;
          if (state_d == S_NL_START) shift_d = C_NEWLINE;
          if (state_d == S_FETCH)    addr_d  = addr_q + 11'd1;
        end
      end
      S_NL_STOP: begin
        if (w_bit_end && (state_d == S_FETCH)) addr_d = addr_q + 11'd1;
      end
      default: ;
    endcase

    case (state_q)
      S_START, S_NL_START: tx_d = 1'b0;
      S_DATA, S_NL_DATA:   tx_d = shift_q[0];
      default:             tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d = (state_d == S_FINISH);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign adapter_addr = addr_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_uart_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_uart_dumper
//  Description : Self-checking bench for ram_uart_dumper: three instances
//                (raw single word, hex matrix, wrap with latency 2) sharing a
//                behavioural RAM; a UART decoder feeds a byte/address
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_uart_dumper;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        start_a, start_b, start_c;
  logic [10:0] addr_a, addr_b, addr_c;
  logic [31:0] data_a, data_b, data_c;
  logic        tx_a, tx_b, tx_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  logic [31:0] mem [0:2047];
  logic [31:0] rd_a, rd_b, rd_c1, rd_c2;

  int          sel;
  logic        mon_tx, mon_busy, mon_done;
  logic [10:0] mon_addr;

  int n_vec;
  int n_err;

  logic [7:0]  exp_byte_q [$];
  logic [10:0] exp_addr_q [$];

  ram_uart_dumper #(.CLK_FREQ(8), .BAUD(2), .BASE_ADDR(0), .NUM_WORDS(1),
                    .READ_LATENCY(1), .ASCII_MODE(0), .ROW_LEN(10)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .adapter_addr(addr_a),
    .adapter_data(data_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  ram_uart_dumper #(.CLK_FREQ(8), .BAUD(2), .BASE_ADDR(0), .NUM_WORDS(100),
                    .READ_LATENCY(1), .ASCII_MODE(1), .ROW_LEN(10)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .adapter_addr(addr_b),
    .adapter_data(data_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  ram_uart_dumper #(.CLK_FREQ(8), .BAUD(2), .BASE_ADDR(2046), .NUM_WORDS(3),
                    .READ_LATENCY(2), .ASCII_MODE(0), .ROW_LEN(10)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .adapter_addr(addr_c),
    .adapter_data(data_c), .tx(tx_c), .busy(busy_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read pipelines: latency 1 for a/b, latency 2 for c.
  always @(posedge clk) begin
    rd_a  <= mem[addr_a];
    rd_b  <= mem[addr_b];
    rd_c1 <= mem[addr_c];
    rd_c2 <= rd_c1;
  end
  assign data_a = rd_a;
  assign data_b = rd_b;
  assign data_c = rd_c2;

  always_comb begin
    mon_tx = tx_a; mon_busy = busy_a; mon_done = done_a; mon_addr = addr_a;
    case (sel)
      1: begin mon_tx = tx_b; mon_busy = busy_b; mon_done = done_b; mon_addr = addr_b; end
      2: begin mon_tx = tx_c; mon_busy = busy_c; mon_done = done_c; mon_addr = addr_c; end
      default: ;
    endcase
  end

  task automatic drive_start(input logic v);
    case (sel)
      1:       start_b = v;
      2:       start_c = v;
      default: start_a = v;
    endcase
  endtask

  function automatic logic [7:0] hex_of(input logic [3:0] v);
    logic [7:0] r;
    r = (v < 4'd10) ? (8'h30 + {4'd0, v}) : (8'h37 + {4'd0, v});
    return r;
  endfunction

  // Pulses start on the selected DUT, decodes its TX line and compares each
  // byte (and the address held before its start bit) with the scoreboard.
  task automatic run_dump(input int max_cyc, input int pulse_at, input int exp_bytes);
    int c, ph, nbytes, ndone, post, bitn;
    bit active, seen_done;
    logic [7:0]  sh, eb;
    logic [10:0] h0, h1, h2, ea;
    c = 0; ph = 0; nbytes = 0; ndone = 0; post = 0;
    active = 0; seen_done = 0; sh = '0; h0 = '0; h1 = '0; h2 = '0;
    @(negedge clk);
    drive_start(1'b1);
    forever begin
      @(negedge clk);
      c++;
      if (c == 1) drive_start(1'b0);
      if (c == pulse_at) drive_start(1'b1);
      if (c == pulse_at + 1) drive_start(1'b0);
      if (mon_done === 1'b1) begin ndone++; seen_done = 1; end
      if (!active) begin
        if (mon_tx === 1'b0) begin
          active = 1; ph = 0;
          if (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            n_vec++;
            if (!(h0 === ea && h1 === ea && h2 === ea)) begin
              n_err++;
              $display("FAIL addr_hold sel=%0d got %0d,%0d,%0d expected %0d", sel, h2, h1, h0, ea);
            end
          end
        end
      end else begin
        ph++;
      end
      if (active && (ph % CPB) == CPB / 2) begin
        bitn = ph / CPB;
        if (bitn >= 1 && bitn <= 8) sh[bitn-1] = mon_tx;
        if (bitn == 9) begin
          nbytes++;
          n_vec++;
          if (exp_byte_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_byte sel=%0d got 0x%02h expected none", sel, sh);
          end else begin
            eb = exp_byte_q.pop_front();
            if (sh !== eb || mon_tx !== 1'b1) begin
              n_err++;
              $display("FAIL byte sel=%0d #%0d got 0x%02h stop=%b expected 0x%02h stop=1",
                       sel, nbytes, sh, mon_tx, eb);
            end
          end
        end
      end
      if (active && ph == 10 * CPB - 1) active = 0;
      h2 = h1; h1 = h0; h0 = mon_addr;
      if (seen_done) post++;
      if (post > 20) break;
      if (c > max_cyc) begin
        n_vec++; n_err++;
        $display("FAIL timeout sel=%0d got no done after %0d cycles expected done", sel, c);
        break;
      end
    end
    n_vec++;
    if (ndone != 1) begin
      n_err++;
      $display("FAIL done_count sel=%0d got %0d expected 1", sel, ndone);
    end
    n_vec++;
    if (nbytes != exp_bytes || exp_byte_q.size() != 0) begin
      n_err++;
      $display("FAIL byte_count sel=%0d got %0d expected %0d", sel, nbytes, exp_bytes);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({tx_a, busy_a, done_a, addr_a} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
      n_err++;
      $display("FAIL reset_a got tx=%b busy=%b done=%b addr=%0d expected 1 0 0 0", tx_a, busy_a, done_a, addr_a);
    end
    n_vec++;
    if ({tx_b, busy_b, done_b, addr_b} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
      n_err++;
      $display("FAIL reset_b got tx=%b busy=%b done=%b addr=%0d expected 1 0 0 0", tx_b, busy_b, done_b, addr_b);
    end
    n_vec++;
    if ({tx_c, busy_c, done_c, addr_c} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
      n_err++;
      $display("FAIL reset_c got tx=%b busy=%b done=%b addr=%0d expected 1 0 0 0", tx_c, busy_c, done_c, addr_c);
    end
    rst = 1'b0;
  endtask

  // Cycle-exact waveform of a single raw word 0xA5.
  task automatic test_single_word;
    logic [7:0] b;
    logic etx, ebusy, edone;
    b = 8'hA5;
    mem[0] = 32'h0000_00A5;
    sel = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (k < 3)       etx = 1'b1;
      else if (k < 7)  etx = 1'b0;
      else if (k < 39) etx = b[(k - 7) / 4];
      else             etx = 1'b1;
      ebusy = (k < 42);
      edone = (k == 42);
      n_vec++;
      if (tx_a !== etx || busy_a !== ebusy || done_a !== edone) begin
        n_err++;
        $display("FAIL single_word cycle %0d got tx=%b busy=%b done=%b expected %b %b %b",
                 k, tx_a, busy_a, done_a, etx, ebusy, edone);
      end
    end
  endtask

  task automatic test_matrix_dump;
    sel = 1;
    exp_byte_q.delete(); exp_addr_q.delete();
    for (int i = 0; i < 100; i++) mem[i] = 32'(i % 16) | 32'hFFF0_0000;
    for (int i = 0; i < 100; i++) begin
      exp_byte_q.push_back(hex_of(4'(i % 16)));
      exp_addr_q.push_back(11'(i));
      if ((i + 1) % 10 == 0) begin
        exp_byte_q.push_back(8'h0A);
        exp_addr_q.push_back(11'(i));
      end
    end
    run_dump(6000, -10, 110);
  endtask

  task automatic test_wrap_latency;
    sel = 2;
    mem[2046] = 32'h1234_5678;
    mem[2047] = 32'hDEAD_BE3C;
    mem[0]    = 32'h0000_00C1;
    exp_byte_q.delete(); exp_addr_q.delete();
    exp_byte_q.push_back(8'h78); exp_addr_q.push_back(11'd2046);
    exp_byte_q.push_back(8'h3C); exp_addr_q.push_back(11'd2047);
    exp_byte_q.push_back(8'hC1); exp_addr_q.push_back(11'd0);
    run_dump(400, -10, 3);
  endtask

  task automatic test_start_while_busy;
    sel = 2;
    mem[2046] = 32'h0000_0011;
    mem[2047] = 32'h0000_0096;
    mem[0]    = 32'h0000_00FE;
    exp_byte_q.delete(); exp_addr_q.delete();
    exp_byte_q.push_back(8'h11); exp_addr_q.push_back(11'd2046);
    exp_byte_q.push_back(8'h96); exp_addr_q.push_back(11'd2047);
    exp_byte_q.push_back(8'hFE); exp_addr_q.push_back(11'd0);
    run_dump(400, 60, 3);
  endtask

  task automatic test_reset_mid_frame;
    int ndone;
    int nlow;
    sel = 0;
    mem[0] = 32'h0000_00A5;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({tx_a, busy_a, done_a, addr_a} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
      n_err++;
      $display("FAIL mid_reset got tx=%b busy=%b done=%b addr=%0d expected 1 0 0 0", tx_a, busy_a, done_a, addr_a);
    end
    rst = 1'b0;
    ndone = 0; nlow = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) ndone++;
      if (tx_a !== 1'b1) nlow++;
    end
    n_vec++;
    if (ndone != 0 || nlow != 0) begin
      n_err++;
      $display("FAIL after_reset got done_cycles=%0d tx_low_cycles=%0d expected 0 0", ndone, nlow);
    end
    exp_byte_q.delete(); exp_addr_q.delete();
    exp_byte_q.push_back(8'hA5); exp_addr_q.push_back(11'd0);
    run_dump(200, -10, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; sel = 0;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
    test_reset;
    test_single_word;
    test_matrix_dump;
    test_wrap_latency;
    test_start_while_busy;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
